instr_control: RTL and testbench

INSTR_CONTROL -- requirements
Module: instr_control

---
 rtl/instr_control.sv | 213 +++++++++++++++++++++
 tb/tb_instr_control.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_control.sv
// Moore control FSM for a 16-bit load/store CPU: fetches into IR, decodes,
// and sequences register-file, ALU and memory controls one state per cycle.
module instr_control #(
  parameter logic [8:0] RESET_PC = 9'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] read_data,
  input  logic [15:0] datapath_out,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [7:0]  pc_out,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        halted
);

  localparam logic [4:0] S_RST   = 5'd0;
  localparam logic [4:0] S_IF1   = 5'd1;
  localparam logic [4:0] S_IF2   = 5'd2;
  localparam logic [4:0] S_UPD   = 5'd3;
  localparam logic [4:0] S_DEC   = 5'd4;
  localparam logic [4:0] S_WIMM  = 5'd5;
  localparam logic [4:0] S_GETA  = 5'd6;
  localparam logic [4:0] S_GETB  = 5'd7;
  localparam logic [4:0] S_EXEC  = 5'd8;
  localparam logic [4:0] S_WREG  = 5'd9;
  localparam logic [4:0] S_ADDR  = 5'd10;
  localparam logic [4:0] S_LADDR = 5'd11;
  localparam logic [4:0] S_MRD   = 5'd12;
  localparam logic [4:0] S_LWB   = 5'd13;
  localparam logic [4:0] S_STRB  = 5'd14;
  localparam logic [4:0] S_STRC  = 5'd15;
  localparam logic [4:0] S_MWR   = 5'd16;
  localparam logic [4:0] S_HALT  = 5'd17;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  logic [4:0]  state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [8:0]  da_q, da_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_halt;
  logic       unused_dp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt = (opcode == 3'b111);

  assign sximm8    = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5    = {{11{ir_q[4]}}, ir_q[4:0]};
  assign pc_out    = pc_q[7:0];
  assign unused_dp = ^datapath_out[15:9];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    da_d    = da_q;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      S_IF2: begin
        ir_d    = read_data;
        state_d = S_UPD;
      end
      S_UPD: begin
        pc_d    = pc_q + 9'd1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (is_movi)                          state_d = S_WIMM;
        else if (is_movr)                     state_d = S_GETB;
        else if (is_alu || is_ldr || is_str)  state_d = S_GETA;
        else if (is_halt)                     state_d = S_HALT;
        else                                  state_d = S_IF1;
      end
      S_WIMM: state_d = S_IF1;
      S_GETA: state_d = is_alu ? S_GETB : S_ADDR;
      S_GETB: state_d = S_EXEC;
      S_EXEC: state_d = is_cmp ? S_IF1 : S_WREG;
      S_WREG: state_d = S_IF1;
      S_ADDR: state_d = S_LADDR;
      S_LADDR: begin
        // Effective address computed in ADDR is latched here for MRD/MWR.
        da_d    = datapath_out[8:0];
        state_d = is_ldr ? S_MRD : S_STRB;
      end
      S_MRD:  state_d = S_LWB;
      S_LWB:  state_d = S_IF1;
      S_STRB: state_d = S_STRC;
      S_STRC: state_d = S_MWR;
      S_MWR:  state_d = S_IF1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    mem_cmd  = MEM_NONE;
    mem_addr = da_q;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    vsel     = 2'd0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IF1, S_IF2: begin
        mem_cmd  = MEM_READ;
        mem_addr = pc_q;
      end
      S_WIMM: begin
        vsel     = 2'd2;
        write    = 1'b1;
        writenum = rn;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = sh;
      end
      S_EXEC: begin
        // MOV reg passes B through by zeroing the A operand.
        shift = sh;
        asel  = is_movr;
        ALUop = is_alu ? op : 2'b00;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WREG: begin
        write    = 1'b1;
        writenum = rd;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_MRD: mem_cmd = MEM_READ;
      S_LWB: begin
        mem_cmd  = MEM_READ;
        vsel     = 2'd3;
        write    = 1'b1;
        writenum = rd;
      end
      S_STRB: begin
        readnum = rd;
        loadb   = 1'b1;
      end
      S_STRC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR:  mem_cmd = MEM_WRITE;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= 16'd0;
      da_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      da_q    <= da_d;
    end
  end

endmodule

// File: tb/tb_instr_control.sv
// Self-checking bench for instr_control: each instruction is expanded into its
// per-cycle control program and compared against the DUT cycle by cycle.
module tb_instr_control;

  localparam logic [8:0] RESET_PC = 9'd0;

  localparam int C_NOP  = 0;
  localparam int C_MOVI = 1;
  localparam int C_MOVR = 2;
  localparam int C_ALU  = 3;
  localparam int C_CMP  = 4;
  localparam int C_LDR  = 5;
  localparam int C_STR  = 6;
  localparam int C_HALT = 7;

  typedef struct packed {
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [7:0]  pc_out;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] read_data;
  logic [15:0] datapath_out;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [7:0]  pc_out;
  logic [15:0] sximm8, sximm5;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop, vsel;
  logic        loada, loadb, asel, bsel, loadc, loads, write, halted;
  ctl_t        obs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  m_pc;
  logic [15:0] m_ir;
  logic [8:0]  m_da;
  ctl_t        got_q[$];
  ctl_t        exp_q[$];

  always #5 clk = ~clk;

  instr_control #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .read_data(read_data), .datapath_out(datapath_out),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .pc_out(pc_out),
    .sximm8(sximm8), .sximm5(sximm5), .readnum(readnum), .writenum(writenum),
    .shift(shift), .ALUop(ALUop), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .write(write),
    .halted(halted)
  );

  assign obs = {mem_cmd, mem_addr, pc_out, sximm8, sximm5, readnum, writenum,
                shift, ALUop, vsel, loada, loadb, asel, bsel, loadc, loads, write, halted};

  function automatic int classify(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] o;
    opc = ir[15:13];
    o   = ir[12:11];
    if (opc == 3'b110 && o == 2'b10) return C_MOVI;
    if (opc == 3'b110 && o == 2'b00) return C_MOVR;
    if (opc == 3'b101) return (o == 2'b01) ? C_CMP : C_ALU;
    if (opc == 3'b011 && o == 2'b00) return C_LDR;
    if (opc == 3'b100 && o == 2'b00) return C_STR;
    if (opc == 3'b111) return C_HALT;
    return C_NOP;
  endfunction

  // Cycles from IF1 back to IF1 for each instruction kind.
  function automatic int instr_len(input logic [15:0] ir);
    case (classify(ir))
      C_MOVI: return 5;
      C_MOVR: return 7;
      C_CMP:  return 7;
      C_ALU:  return 8;
      C_LDR:  return 9;
      C_STR:  return 10;
      C_HALT: return 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] rand_instr(input int c);
    logic [15:0] r;
    r = 16'($urandom);
    case (c)
      C_MOVI: r[15:11] = 5'b11010;
      C_MOVR: r[15:11] = 5'b11000;
      C_ALU:  r[15:13] = 3'b101;
      C_CMP:  r[15:11] = 5'b10101;
      C_LDR:  r[15:11] = 5'b01100;
      C_STR:  r[15:11] = 5'b10000;
      C_HALT: r[15:13] = 3'b111;
      default: begin
        r[15:13] = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) r[15:11] = 5'b11001;
      end
    endcase
    return r;
  endfunction

  // Expected outputs k cycles after IF1 for instruction ir; pc/old_ir/da_old are
  // the architectural values at the start of the instruction.
  function automatic ctl_t expect_at(input logic [15:0] ir, input int k, input logic [8:0] pc,
                                     input logic [15:0] old_ir, input logic [8:0] da_old,
                                     input logic [15:0] dout);
    ctl_t e;
    int c;
    logic [15:0] cur;
    logic [8:0] pc1;
    e   = '0;
    c   = classify(ir);
    cur = (k < 2) ? old_ir : ir;
    pc1 = pc + 9'd1;
    e.sximm8 = {{8{cur[7]}}, cur[7:0]};
    e.sximm5 = {{11{cur[4]}}, cur[4:0]};
    e.pc_out = (k < 3) ? pc[7:0] : pc1[7:0];
    if (k < 2) begin
      e.mem_cmd  = 2'b01;
      e.mem_addr = pc;
      return e;
    end
    e.mem_addr = ((c == C_LDR || c == C_STR) && k >= 7) ? dout[8:0] : da_old;
    case (c)
      C_MOVI: if (k == 4) begin e.vsel = 2'd2; e.write = 1'b1; e.writenum = ir[10:8]; end
      C_MOVR: begin
        if (k == 4) begin e.readnum = ir[2:0]; e.loadb = 1'b1; e.shift = ir[4:3]; end
        if (k == 5) begin e.shift = ir[4:3]; e.asel = 1'b1; e.loadc = 1'b1; end
        if (k == 6) begin e.write = 1'b1; e.writenum = ir[7:5]; end
      end
      C_ALU, C_CMP: begin
        if (k == 4) begin e.readnum = ir[10:8]; e.loada = 1'b1; end
        if (k == 5) begin e.readnum = ir[2:0]; e.loadb = 1'b1; e.shift = ir[4:3]; end
        if (k == 6) begin
          e.shift = ir[4:3];
          e.ALUop = ir[12:11];
          if (c == C_CMP) e.loads = 1'b1;
          else e.loadc = 1'b1;
        end
        if (k == 7) begin e.write = 1'b1; e.writenum = ir[7:5]; end
      end
      C_LDR, C_STR: begin
        if (k == 4) begin e.readnum = ir[10:8]; e.loada = 1'b1; end
        if (k == 5) begin e.bsel = 1'b1; e.loadc = 1'b1; end
        if (c == C_LDR) begin
          if (k == 7) e.mem_cmd = 2'b01;
          if (k == 8) begin e.mem_cmd = 2'b01; e.vsel = 2'd3; e.write = 1'b1; e.writenum = ir[7:5]; end
        end else begin
          if (k == 7) begin e.readnum = ir[7:5]; e.loadb = 1'b1; end
          if (k == 8) begin e.asel = 1'b1; e.loadc = 1'b1; end
          if (k == 9) e.mem_cmd = 2'b10;
        end
      end
      C_HALT: if (k >= 4) e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t expect_rst();
    ctl_t e;
    e = '0;
    e.pc_out = RESET_PC[7:0];
    return e;
  endfunction

  // Runs ncyc cycles of instr starting in IF1. read_data and datapath_out carry
  // junk except in the single cycle where the DUT is meant to capture them.
  task automatic run_cycles(input logic [15:0] instr, input logic [15:0] dout, input int ncyc);
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      read_data    = (k == 1) ? instr : 16'($urandom);
      datapath_out = (k == 6) ? dout : 16'($urandom);
      got_q.push_back(obs);
      exp_q.push_back(expect_at(instr, k, m_pc, m_ir, m_da, dout));
      @(posedge clk);
      #1;
    end
    if (classify(instr) != C_HALT && ncyc >= instr_len(instr)) begin
      m_pc = m_pc + 9'd1;
      m_ir = instr;
      if (classify(instr) == C_LDR || classify(instr) == C_STR) m_da = dout[8:0];
    end
  endtask

  task automatic apply_reset(input int ncyc);
    got_q.delete();
    exp_q.delete();
    reset_n = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      read_data    = 16'($urandom);
      datapath_out = 16'($urandom);
      @(posedge clk);
      #1;
      got_q.push_back(obs);
      exp_q.push_back(expect_rst());
    end
    reset_n = 1'b1;
    m_pc = RESET_PC;
    m_ir = 16'd0;
    m_da = 9'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (mem_cmd !== 2'b01 || mem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_release_if1 got cmd=%b addr=%h exp cmd=01 addr=%h", mem_cmd, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_mov_imm();
    run_cycles(16'hD007, 16'h0000, 4);
    n_tests++;
    if (write !== 1'b1 || vsel !== 2'd2 || writenum !== 3'd0 || sximm8 !== 16'h0007 || pc_out !== 8'd1) begin
      n_fail++;
      $display("FAIL mov_imm_wimm got w=%b vsel=%0d wn=%0d imm=%h pc=%0d exp w=1 vsel=2 wn=0 imm=0007 pc=1",
               write, vsel, writenum, sximm8, pc_out);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mov_imm cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk);
    #1;
    m_pc = m_pc + 9'd1;
    m_ir = 16'hD007;
  endtask

  task automatic test_alu();
    logic [15:0] prog[$];
    prog.push_back(16'hA0A9);
    prog.push_back(16'hA901);
    for (int n = 0; n < 16; n++)
      prog.push_back(rand_instr($urandom_range(C_MOVR, C_CMP)));
    foreach (prog[p]) begin
      run_cycles(prog[p], 16'($urandom), instr_len(prog[p]));
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL alu instr=%h cyc%0d got=%h exp=%h", prog[p], i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_load_store();
    logic [15:0] prog[$];
    logic [15:0] dd[$];
    prog.push_back(16'h615F);
    dd.push_back(16'h0123);
    for (int n = 0; n < 12; n++) begin
      prog.push_back(rand_instr(($urandom_range(0, 1) == 0) ? C_LDR : C_STR));
      dd.push_back(16'($urandom));
    end
    foreach (prog[p]) begin
      run_cycles(prog[p], dd[p], instr_len(prog[p]));
      if (p == 0) begin
        n_tests++;
        if (got_q[8].mem_addr !== 9'h123 || got_q[8].mem_cmd !== 2'b01 || got_q[8].vsel !== 2'd3 ||
            got_q[8].writenum !== 3'd2 || got_q[8].write !== 1'b1) begin
          n_fail++;
          $display("FAIL ldr_lwb got=%h exp addr=123 cmd=01 vsel=3 wn=2 w=1", got_q[8]);
        end
      end
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL ldst instr=%h cyc%0d got=%h exp=%h", prog[p], i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_mix();
    logic [15:0] ins;
    for (int n = 0; n < 40; n++) begin
      ins = rand_instr($urandom_range(C_NOP, C_STR));
      run_cycles(ins, 16'($urandom), instr_len(ins));
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL mix instr=%h cyc%0d got=%h exp=%h", ins, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] ins, dout;
    int k;
    ctl_t e;
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin ins = rand_instr(C_STR); k = 9; end
      else if (n == 1) begin ins = rand_instr(C_LDR); k = 8; end
      else begin
        ins = rand_instr($urandom_range(C_NOP, C_STR));
        k = $urandom_range(0, instr_len(ins) - 1);
      end
      dout = 16'($urandom);
      run_cycles(ins, dout, k);
      e = expect_at(ins, k, m_pc, m_ir, m_da, dout);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_pre instr=%h cyc%0d got=%h exp=%h", ins, k, obs, e);
      end
      apply_reset((n < 2) ? 1 : $urandom_range(1, 3));
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL abort_rst instr=%h cyc%0d got=%h exp=%h", ins, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_halt();
    run_cycles(16'hD203, 16'h0000, 5);
    run_cycles(16'hE000, 16'($urandom), 4 + 22);
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL halt cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (halted !== 1'b1 || mem_cmd !== 2'b00 || pc_out !== 8'(m_pc + 9'd1)) begin
      n_fail++;
      $display("FAIL halt_hold got h=%b cmd=%b pc=%0d exp h=1 cmd=00 pc=%0d", halted, mem_cmd, pc_out, m_pc + 9'd1);
    end
    apply_reset(2);
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL halt_rst cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [15:0] ins;
    apply_reset(1);
    for (int n = 0; n < 512; n++) begin
      ins = rand_instr(C_NOP);
      run_cycles(ins, 16'h0000, 4);
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL pc_walk n=%0d cyc%0d got=%h exp=%h", n, i, got_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h000 || pc_out !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap got cmd=%b addr=%h pc=%h exp cmd=01 addr=000 pc=00", mem_cmd, mem_addr, pc_out);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    read_data    = 16'h0000;
    datapath_out = 16'h0000;
    m_pc         = RESET_PC;
    m_ir         = 16'd0;
    m_da         = 9'd0;
    test_reset();
    test_mov_imm();
    test_alu();
    test_load_store();
    test_random_mix();
    test_reset_abort();
    test_halt();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
